// File: rtl/probe_trace_buffer.sv
// probe_trace_buffer: samples probe channels every cycle and logs {ts, change mask, snapshot}
// into a trace FIFO on any enabled change; drained through a valid/ready port.
module probe_trace_buffer #(
    parameter int NUM_CH    = 13,
    parameter int CH_W      = 32,
    parameter int DEPTH     = 16,
    parameter int TS_W      = 32,
    parameter int WRAP_MODE = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CH*CH_W-1:0]    probe,
    input  logic [NUM_CH-1:0]         ch_en,
    input  logic                      arm,
    input  logic                      disarm,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic [TS_W-1:0]           rd_ts,
    output logic [NUM_CH-1:0]         rd_mask,
    output logic [NUM_CH*CH_W-1:0]    rd_data,
    output logic [$clog2(DEPTH):0]    count,
    output logic [15:0]               dropped,
    output logic                      capturing
);
    localparam int AW = $clog2(DEPTH);
    localparam int W  = NUM_CH * CH_W;

    typedef enum logic [1:0] {IDLE, CAPTURE, FULL, STOPPED} state_t;

    state_t            state;
    logic [TS_W-1:0]   ts;
    logic [W-1:0]      prev;
    logic              first_flag;
    logic [AW:0]       wr_ptr, rd_ptr, count_next;
    logic [NUM_CH-1:0] chg;
    logic              hit, full, pop, push, overwrite, drop, full_next;

    logic [TS_W-1:0]   mem_ts   [DEPTH];
    logic [NUM_CH-1:0] mem_mask [DEPTH];
    logic [W-1:0]      mem_data [DEPTH];

    for (genvar k = 0; k < NUM_CH; k++) begin : g_chg
        assign chg[k] = ch_en[k] && (probe[k*CH_W +: CH_W] != prev[k*CH_W +: CH_W]);
    end

    assign hit       = (|chg) || first_flag;
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_valid  = wr_ptr != rd_ptr;
    assign pop       = rd_valid && rd_ready;
    assign push      = (state == CAPTURE) && hit && (!full || WRAP_MODE != 0);
    // A full-cycle push without a pop displaces the oldest entry.
    assign overwrite = push && full && !pop;
    assign drop      = hit && ((state == FULL) || overwrite);
    assign count     = wr_ptr - rd_ptr;
    assign count_next = count + (AW+1)'(push) - (AW+1)'(pop || overwrite);
    assign full_next = count_next == (AW+1)'(DEPTH);
    assign capturing = state == CAPTURE;

    assign rd_ts   = rd_valid ? mem_ts[rd_ptr[AW-1:0]]   : '0;
    assign rd_mask = rd_valid ? mem_mask[rd_ptr[AW-1:0]] : '0;
    assign rd_data = rd_valid ? mem_data[rd_ptr[AW-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (push && !arm) begin
            mem_ts[wr_ptr[AW-1:0]]   <= ts;
            mem_mask[wr_ptr[AW-1:0]] <= chg | {NUM_CH{first_flag}};
            mem_data[wr_ptr[AW-1:0]] <= probe;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ts         <= '0;
            prev       <= '0;
            first_flag <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            dropped    <= '0;
        end else begin
            ts   <= ts + TS_W'(1);
            prev <= probe;
            if (arm) begin
                state      <= CAPTURE;
                first_flag <= 1'b1;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                dropped    <= '0;
            end else begin
                if (push) begin
                    wr_ptr     <= wr_ptr + (AW+1)'(1);
                    first_flag <= 1'b0;
                end
                if (pop || overwrite)
                    rd_ptr <= rd_ptr + (AW+1)'(1);
                if (drop && dropped != 16'hFFFF)
                    dropped <= dropped + 16'd1;
                case (state)
                    CAPTURE: state <= disarm ? STOPPED : (WRAP_MODE == 0 && full_next) ? FULL : CAPTURE;
                    FULL:    state <= disarm ? STOPPED : full_next ? FULL : CAPTURE;
                    default: state <= state;
                endcase
            end
        end
    end
endmodule
